// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arb_pkg
//  Description : Shared types and reset constants for the two-requester
//                memory arbiter (ram_arb) and its round-robin picker.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package ram_arb_pkg;

    // Arbiter FSM: idle, or holding the response of one requester.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RESP_INST = 2'd1,
        RESP_DATA = 2'd2
    } arb_state_e;

    // Requester identity, used for the round-robin history bit.
    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } arb_src_e;

    // LSU is recorded as last winner at reset so fetch wins the first tie.
    localparam arb_src_e ARB_LAST_RST = SRC_DATA;

    // Bit positions inside the one-hot grant vector.
    localparam int unsigned C_GNT_INST = 0;
    localparam int unsigned C_GNT_DATA = 1;

endpackage

`default_nettype wire

// File: rtl/ram_arb_rr2.sv
`default_nettype none
// ============================================================================
//  Module      : arb_rr2
//  Description : Combinational two-way round-robin picker. With a single
//                valid that requester wins; on a tie the one that did not
//                win last time is chosen. Output is one-hot (or zero).
//  Revision    : 1.0 - initial release
// ============================================================================

module arb_rr2
    import ram_arb_pkg::*;
(
    input  logic     inst_valid_i,
    input  logic     data_valid_i,
    input  arb_src_e last_i,
    output logic [1:0] grant_o
);

    // Pick a winner; ties go to the requester that was not served last.
    always_comb begin
        grant_o = 2'b00;
        if (inst_valid_i && data_valid_i) begin
            if (last_i == SRC_DATA) begin
                grant_o[C_GNT_INST] = 1'b1;
            end else begin
                grant_o[C_GNT_DATA] = 1'b1;
            end
        end else if (inst_valid_i) begin
            grant_o[C_GNT_INST] = 1'b1;
        end else if (data_valid_i) begin
            grant_o[C_GNT_DATA] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_arb.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arb
//  Description : Shares one RAM port between instruction fetch and the LSU.
//                Grants round-robin in IDLE, drives the RAM port for the
//                single grant cycle, registers the result and holds it until
//                the requester accepts it. One transaction outstanding.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module ram_arb
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
    input  logic                    i_sys_clk,
    input  logic                    i_sys_rst,

    // Instruction fetch request / response
    input  logic                    i_arb_inst_req_valid,
    output logic                    o_arb_inst_req_ready,
    input  logic [ADDR_WIDTH-1:0]   i_arb_inst_req_addr,
    output logic                    o_arb_inst_resp_valid,
    input  logic                    i_arb_inst_resp_ready,
    output logic [DATA_WIDTH-1:0]   o_arb_inst_resp_data,

    // Load/store request / response
    input  logic                    i_arb_data_req_valid,
    output logic                    o_arb_data_req_ready,
    input  logic [ADDR_WIDTH-1:0]   i_arb_data_req_addr,
    input  logic                    i_arb_data_req_wr_en,
    input  logic [DATA_WIDTH-1:0]   i_arb_data_req_wr_data,
    input  logic [DATA_WIDTH/8-1:0] i_arb_data_req_wr_mask,
    output logic                    o_arb_data_resp_valid,
    input  logic                    i_arb_data_resp_ready,
    output logic [DATA_WIDTH-1:0]   o_arb_data_resp_data,

    // RAM read ports (combinational read data)
    output logic                    o_ram_rd_inst_en,
    output logic [ADDR_WIDTH-1:0]   o_ram_rd_inst_addr,
    input  logic [DATA_WIDTH-1:0]   i_ram_rd_inst_data,
    output logic                    o_ram_rd_data_en,
    output logic [ADDR_WIDTH-1:0]   o_ram_rd_data_addr,
    input  logic [DATA_WIDTH-1:0]   i_ram_rd_data_data,

    // RAM write port (commits on the grant edge)
    output logic                    o_ram_wr_data_en,
    output logic [ADDR_WIDTH-1:0]   o_ram_wr_data_addr,
    output logic [DATA_WIDTH-1:0]   o_ram_wr_data_data,
    output logic [DATA_WIDTH/8-1:0] o_ram_wr_data_mask
);

    arb_state_e              r_state_q;
    arb_src_e                r_last_q;
    logic                    r_inst_resp_valid_q;
    logic [DATA_WIDTH-1:0]   r_inst_resp_data_q;
    logic                    r_data_resp_valid_q;
    logic [DATA_WIDTH-1:0]   r_data_resp_data_q;

    logic                    w_can_grant;
    logic                    w_inst_cand;
    logic                    w_data_cand;
    logic [1:0]              w_grant;
    logic                    w_gnt_inst;
    logic                    w_gnt_data;
    logic                    w_data_rd;
    logic                    w_data_wr;

    // Requests only compete in IDLE and never while reset is asserted.
    always_comb begin
        w_can_grant = (r_state_q == IDLE) && !i_sys_rst;
        w_inst_cand = i_arb_inst_req_valid && w_can_grant;
        w_data_cand = i_arb_data_req_valid && w_can_grant;
    end

    arb_rr2 u_arb_rr2 (
        .inst_valid_i (w_inst_cand),
        .data_valid_i (w_data_cand),
        .last_i       (r_last_q),
        .grant_o      (w_grant)
    );

    // Decode the grant into the transaction kind driven on the RAM port.
    always_comb begin
        w_gnt_inst = w_grant[C_GNT_INST];
        w_gnt_data = w_grant[C_GNT_DATA];
        w_data_rd  = w_gnt_data && !i_arb_data_req_wr_en;
        w_data_wr  = w_gnt_data &&  i_arb_data_req_wr_en;
    end

    // Request ready and RAM port muxing; idle fields are driven to zero.
    always_comb begin
        o_arb_inst_req_ready = w_gnt_inst;
        o_arb_data_req_ready = w_gnt_data;

        o_ram_rd_inst_en     = w_gnt_inst;
        o_ram_rd_inst_addr   = w_gnt_inst ? i_arb_inst_req_addr : '0;

        o_ram_rd_data_en     = w_data_rd;
        o_ram_rd_data_addr   = w_data_rd ? i_arb_data_req_addr : '0;

        o_ram_wr_data_en     = w_data_wr;
        o_ram_wr_data_addr   = w_data_wr ? i_arb_data_req_addr    : '0;
        o_ram_wr_data_data   = w_data_wr ? i_arb_data_req_wr_data : '0;
        o_ram_wr_data_mask   = w_data_wr ? i_arb_data_req_wr_mask : '0;
    end

    // Arbiter FSM: capture the result on the grant edge, hold until accepted.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_state_q           <= IDLE;
            r_last_q            <= ARB_LAST_RST;
            r_inst_resp_valid_q <= 1'b0;
            r_inst_resp_data_q  <= '0;
            r_data_resp_valid_q <= 1'b0;
            r_data_resp_data_q  <= '0;
        end else begin
            case (r_state_q)
                IDLE: begin
                    if (w_gnt_inst) begin
                        r_inst_resp_data_q  <= i_ram_rd_inst_data;
                        r_inst_resp_valid_q <= 1'b1;
                        r_last_q            <= SRC_INST;
                        r_state_q           <= RESP_INST;
                    end else if (w_gnt_data) begin
                        // Writes answer with zero; reads return the RAM word.
                        r_data_resp_data_q  <= w_data_wr ? '0 : i_ram_rd_data_data;
                        r_data_resp_valid_q <= 1'b1;
                        r_last_q            <= SRC_DATA;
                        r_state_q           <= RESP_DATA;
                    end
                end
                RESP_INST: begin
                    if (i_arb_inst_resp_ready) begin
                        r_inst_resp_valid_q <= 1'b0;
                        r_state_q           <= IDLE;
                    end
                end
                RESP_DATA: begin
                    if (i_arb_data_resp_ready) begin
                        r_data_resp_valid_q <= 1'b0;
                        r_state_q           <= IDLE;
                    end
                end
                default: begin
                    r_inst_resp_valid_q <= 1'b0;
                    r_data_resp_valid_q <= 1'b0;
                    r_state_q           <= IDLE;
                end
            endcase
        end
    end

    // Responses come straight from their holding registers.
    always_comb begin
        o_arb_inst_resp_valid = r_inst_resp_valid_q;
        o_arb_inst_resp_data  = r_inst_resp_data_q;
        o_arb_data_resp_valid = r_data_resp_valid_q;
        o_arb_data_resp_data  = r_data_resp_data_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_arb
//  Description : Self-checking bench for ram_arb. A bench-side RAM plus a
//                transaction-level model predicts ready/enable/response
//                values every cycle; directed scenarios add literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_ram_arb;

    logic        clk;
    logic        rst;
    logic        inst_v, inst_rdy, inst_rv, inst_rr;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_v, data_rdy, data_rv, data_rr, data_wr;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_mask;
    logic        ram_ri_en, ram_rd_en, ram_wr_en;
    logic [31:0] ram_ri_addr, ram_rd_addr, ram_wr_addr, ram_wr_data;
    logic [31:0] ram_ri_q, ram_rd_q;
    logic [3:0]  ram_wr_mask;

    logic [31:0] mem [0:63];
    logic        load_mem;
    logic        cmp_en;

    // Transaction-level model: pending owner (0 none, 1 fetch, 2 LSU)
    int          m_pend;
    logic        m_last_data;
    logic        m_iv, m_dv;
    logic [31:0] m_id, m_dd;

    int errors = 0;
    int checks = 0;

    ram_arb #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .i_sys_clk              (clk),
        .i_sys_rst              (rst),
        .i_arb_inst_req_valid   (inst_v),
        .o_arb_inst_req_ready   (inst_rdy),
        .i_arb_inst_req_addr    (inst_addr),
        .o_arb_inst_resp_valid  (inst_rv),
        .i_arb_inst_resp_ready  (inst_rr),
        .o_arb_inst_resp_data   (inst_rdata),
        .i_arb_data_req_valid   (data_v),
        .o_arb_data_req_ready   (data_rdy),
        .i_arb_data_req_addr    (data_addr),
        .i_arb_data_req_wr_en   (data_wr),
        .i_arb_data_req_wr_data (data_wdata),
        .i_arb_data_req_wr_mask (data_mask),
        .o_arb_data_resp_valid  (data_rv),
        .i_arb_data_resp_ready  (data_rr),
        .o_arb_data_resp_data   (data_rdata),
        .o_ram_rd_inst_en       (ram_ri_en),
        .o_ram_rd_inst_addr     (ram_ri_addr),
        .i_ram_rd_inst_data     (ram_ri_q),
        .o_ram_rd_data_en       (ram_rd_en),
        .o_ram_rd_data_addr     (ram_rd_addr),
        .i_ram_rd_data_data     (ram_rd_q),
        .o_ram_wr_data_en       (ram_wr_en),
        .o_ram_wr_data_addr     (ram_wr_addr),
        .o_ram_wr_data_data     (ram_wr_data),
        .o_ram_wr_data_mask     (ram_wr_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational-read RAM, word addressed by byte address bits [7:2]
    assign ram_ri_q = mem[ram_ri_addr[7:2]];
    assign ram_rd_q = mem[ram_rd_addr[7:2]];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Who the rules say must be granted right now: {lsu, fetch}
    function automatic logic [1:0] exp_grant();
        if (rst || m_pend != 0)   return 2'b00;
        if (inst_v && data_v)     return m_last_data ? 2'b01 : 2'b10;
        return {data_v, inst_v};
    endfunction

    // RAM contents and transaction model advance on each rising edge
    always @(posedge clk) begin
        logic [1:0] g;
        g = exp_grant();
        if (load_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h5000_0000 + 32'(i);
            mem[0] <= 32'h1111_0000;
            mem[1] <= 32'h2222_0001;
            mem[4] <= 32'h1234_5678;
            mem[8] <= 32'hAAAA_AAAA;
        end else if (ram_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_wr_mask[b]) mem[ram_wr_addr[7:2]][8*b +: 8] <= ram_wr_data[8*b +: 8];
        end
        if (rst) begin
            m_pend <= 0; m_last_data <= 1'b1;
            m_iv <= 1'b0; m_dv <= 1'b0; m_id <= '0; m_dd <= '0;
        end else if (g[0]) begin
            m_id <= mem[inst_addr[7:2]]; m_iv <= 1'b1; m_pend <= 1; m_last_data <= 1'b0;
        end else if (g[1]) begin
            m_dd <= data_wr ? 32'h0 : mem[data_addr[7:2]];
            m_dv <= 1'b1; m_pend <= 2; m_last_data <= 1'b1;
        end else if (m_pend == 1 && inst_rr) begin
            m_iv <= 1'b0; m_pend <= 0;
        end else if (m_pend == 2 && data_rr) begin
            m_dv <= 1'b0; m_pend <= 0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic [1:0] g;
        logic       rd, wr;
        if (cmp_en) begin
            g  = exp_grant();
            rd = g[1] && !data_wr;
            wr = g[1] &&  data_wr;
            chk1 ("inst_req_ready", inst_rdy,  g[0]);
            chk1 ("data_req_ready", data_rdy,  g[1]);
            chk1 ("ram_rd_inst_en", ram_ri_en, g[0]);
            chk1 ("ram_rd_data_en", ram_rd_en, rd);
            chk1 ("ram_wr_data_en", ram_wr_en, wr);
            chk32("ram_rd_inst_addr", ram_ri_addr, g[0] ? inst_addr : 32'h0);
            chk32("ram_rd_data_addr", ram_rd_addr, rd ? data_addr : 32'h0);
            chk32("ram_wr_data_addr", ram_wr_addr, wr ? data_addr : 32'h0);
            chk32("ram_wr_data_data", ram_wr_data, wr ? data_wdata : 32'h0);
            chk32("ram_wr_data_mask", 32'(ram_wr_mask), wr ? 32'(data_mask) : 32'h0);
            chk1 ("inst_resp_valid", inst_rv, m_iv);
            chk1 ("data_resp_valid", data_rv, m_dv);
            if (m_iv) chk32("inst_resp_data", inst_rdata, m_id);
            if (m_dv) chk32("data_resp_data", data_rdata, m_dd);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cmp_en = 1'b0; load_mem = 1'b1; rst = 1'b1;
        inst_v = 0; inst_addr = 0; inst_rr = 1;
        data_v = 0; data_addr = 0; data_wr = 0; data_wdata = 0; data_mask = 0; data_rr = 1;
        step();
        load_mem = 1'b0; cmp_en = 1'b1;
        inst_v = 1; data_v = 1;
        @(negedge clk);
        chk1("rst_no_inst_grant", inst_rdy, 1'b0);
        chk1("rst_no_data_grant", data_rdy, 1'b0);
        step();
        rst = 1'b0; inst_v = 0; data_v = 0;
        @(negedge clk);
        chk1 ("reset_inst_resp_valid", inst_rv, 1'b0);
        chk32("reset_inst_resp_data", inst_rdata, 32'h0);
        chk32("reset_data_resp_data", data_rdata, 32'h0);
        chk1 ("reset_rd_inst_en", ram_ri_en, 1'b0);

        // Tie after reset: fetch, LSU, fetch, ...
        step();
        inst_v = 1; inst_addr = 32'h0; data_v = 1; data_addr = 32'h4;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk1($sformatf("tie%0d_inst_ready", k), inst_rdy, (k % 2) == 0);
            chk1($sformatf("tie%0d_data_ready", k), data_rdy, (k % 2) == 1);
            step();
            @(negedge clk);
            if ((k % 2) == 0) begin
                chk1 ($sformatf("tie%0d_inst_rv", k), inst_rv, 1'b1);
                chk32($sformatf("tie%0d_inst_data", k), inst_rdata, 32'h1111_0000);
            end else begin
                chk1 ($sformatf("tie%0d_data_rv", k), data_rv, 1'b1);
                chk32($sformatf("tie%0d_data_data", k), data_rdata, 32'h2222_0001);
            end
            step();
        end
        inst_v = 0; data_v = 0;

        // Fetch only
        inst_v = 1; inst_addr = 32'h10;
        @(negedge clk);
        chk1("fetch_ready", inst_rdy, 1'b1);
        chk1("fetch_no_rd_data_en", ram_rd_en, 1'b0);
        step();
        inst_v = 0;
        @(negedge clk);
        chk1 ("fetch_resp_valid", inst_rv, 1'b1);
        chk32("fetch_resp_data", inst_rdata, 32'h1234_5678);
        chk1 ("fetch_resp_no_rd_data_en", ram_rd_en, 1'b0);
        step();

        // LSU masked write, then read back
        data_v = 1; data_wr = 1; data_addr = 32'h20; data_wdata = 32'hDEAD_BEEF; data_mask = 4'b0011;
        @(negedge clk);
        chk1("wr_en", ram_wr_en, 1'b1);
        chk1("wr_no_rd_en", ram_rd_en, 1'b0);
        step();
        data_v = 0; data_wr = 0;
        @(negedge clk);
        chk1 ("wr_resp_valid", data_rv, 1'b1);
        chk32("wr_resp_data", data_rdata, 32'h0);
        step();
        data_v = 1; data_addr = 32'h20;
        @(negedge clk);
        chk1("rd20_ready", data_rdy, 1'b1);
        step();
        data_v = 0;
        @(negedge clk);
        chk32("rd20_data", data_rdata, 32'hAAAA_BEEF);
        step();

        // Response backpressure with both requesters waiting
        inst_rr = 0; inst_v = 1; inst_addr = 32'h10;
        @(negedge clk);
        chk1("bp_grant", inst_rdy, 1'b1);
        step();
        data_v = 1; data_addr = 32'h4;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk1 ($sformatf("bp%0d_valid", k), inst_rv, 1'b1);
            chk32($sformatf("bp%0d_data", k), inst_rdata, 32'h1234_5678);
            chk1 ($sformatf("bp%0d_inst_ready", k), inst_rdy, 1'b0);
            chk1 ($sformatf("bp%0d_data_ready", k), data_rdy, 1'b0);
            chk1 ($sformatf("bp%0d_no_rd_en", k), ram_ri_en | ram_rd_en | ram_wr_en, 1'b0);
            step();
        end
        inst_rr = 1;
        @(negedge clk);
        chk1("bp_release_valid", inst_rv, 1'b1);
        step();
        @(negedge clk);
        chk1("bp_after_tie_data", data_rdy, 1'b1);
        chk1("bp_after_tie_inst", inst_rdy, 1'b0);
        step();
        inst_v = 0; data_v = 0;
        @(negedge clk);
        chk32("bp_after_data", data_rdata, 32'h2222_0001);
        step();

        // Reset while an LSU response is pending
        data_v = 1; data_addr = 32'h4;
        @(negedge clk);
        chk1("rr_grant", data_rdy, 1'b1);
        step();
        data_v = 0; data_rr = 0;
        @(negedge clk);
        chk1("rr_pending", data_rv, 1'b1);
        step();
        rst = 1; inst_v = 1; data_v = 1; data_wr = 1;
        data_addr = 32'h20; data_wdata = 32'h0; data_mask = 4'hF;
        @(negedge clk);
        chk1("rr_no_write_in_reset", ram_wr_en, 1'b0);
        step();
        rst = 0; data_wr = 0; data_addr = 32'h4; inst_addr = 32'h0; data_rr = 1;
        @(negedge clk);
        chk1("rr_resp_dropped", data_rv, 1'b0);
        chk1("rr_tie_fetch", inst_rdy, 1'b1);
        chk1("rr_tie_not_data", data_rdy, 1'b0);
        step();
        inst_v = 0; data_v = 0;
        @(negedge clk);
        chk32("rr_fetch_data", inst_rdata, 32'h1111_0000);
        step();
        data_v = 1; data_addr = 32'h20;
        step();
        data_v = 0;
        @(negedge clk);
        chk32("rr_mem_untouched", data_rdata, 32'hAAAA_BEEF);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
